// File: rtl/wts_mixer_pkg.sv
// Shared types and helpers for the time-multiplexed channel mixer.
package wts_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mixer_state_t;

  // Accumulator width that cannot overflow when every channel contributes its
  // largest product.
  function automatic int acc_w(int num_ch, int sample_w, int vol_w);
    return sample_w + vol_w + 1 + $clog2(num_ch);
  endfunction

  // Clip (or wrap) a scaled sum to out_w signed bits, then flip the MSB to get
  // offset binary. The caller keeps the low out_w bits of the result.
  function automatic logic [31:0] to_offset_binary(logic signed [63:0] s,
                                                   int out_w, bit saturate);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] c;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    c  = s;
    if (saturate) begin
      if (s > hi)      c = hi;
      else if (s < lo) c = lo;
    end
    return c[31:0] ^ (32'd1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/wts_channel_mixer_tdm_mac.sv
// One mix accumulator: clear, conditional multiply-add, and final scale/clip
// into a registered offset-binary output.
module wts_mixer_mac
  import wts_mixer_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 4,
  parameter int ACC_W    = 17,
  parameter int OUT_W    = 12,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                clr_i,
  input  logic                cap_i,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [VOL_W-1:0]    volume_i,
  input  logic                load_i,
  input  logic [3:0]          shift_i,
  input  logic                mute_i,
  output logic [OUT_W-1:0]    out_o
);

  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d, scaled;
  logic [OUT_W-1:0]         out_q, out_d;

  // Multiply-add and output formatting for the next clock edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    acc_d  = acc_q;
    out_d  = out_q;
    prod   = PROD_W'($signed(sample_i)) * PROD_W'($signed({1'b0, volume_i}));
    scaled = acc_q >>> shift_i;
    if (clr_i)              acc_d = '0;
    else if (cap_i && en_i) acc_d = acc_q + ACC_W'(prod);
    if (load_i) begin
      out_d = mute_i ? MID
                     : OUT_W'(to_offset_binary(64'(scaled), OUT_W, SATURATE != 0));
    end
  end

  // Accumulator and output registers; reset parks the output at midpoint.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!nreset) begin
      acc_q <= '0;
      out_q <= MID;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/wts_channel_mixer_tdm.sv
// Time-multiplexed stereo mixer: scans channels over a shared select bus,
// accumulates volume-scaled samples per side and emits offset-binary results.
module wts_channel_mixer_tdm
  import wts_mixer_pkg::*;
#(
  parameter int NUM_CH      = 12,
  parameter int SAMPLE_W    = 8,
  parameter int VOL_W       = 4,
  parameter int OUT_W       = 12,
  parameter int SRC_LATENCY = 2,
  parameter int SATURATE    = 1
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      sample_tick,
  input  logic [3:0]                master_shift,
  input  logic                      mute,
  input  logic                      overrun_clr,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  input  logic [SAMPLE_W-1:0]       ch_sample,
  input  logic [VOL_W-1:0]          ch_volume,
  input  logic [1:0]                ch_enable,
  output logic                      busy,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          left_out,
  output logic [OUT_W-1:0]          right_out,
  output logic                      overrun
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int ACC_W = acc_w(NUM_CH, SAMPLE_W, VOL_W);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  mixer_state_t     state_q, state_d;
  logic [SEL_W-1:0] ch_sel_q, ch_sel_d;
  logic [2:0]       drain_q, drain_d;
  logic [3:0]       shift_q, shift_d;
  logic             mute_q, mute_d;
  logic             overrun_q, overrun_d;
  logic             valid_q;
  logic             start, load, in_scan, cap_valid;

  // Next-state, channel counter and frame-setup decode.
  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    drain_d  = drain_q;
    shift_d  = shift_q;
    mute_d   = mute_q;
    start    = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: if (sample_tick) begin
        start    = 1'b1;
        shift_d  = master_shift;
        mute_d   = mute;
        ch_sel_d = '0;
        state_d  = SCAN;
      end
      SCAN: if (ch_sel_q == LAST_CH) begin
        ch_sel_d = '0;
        drain_d  = '0;
        state_d  = (SRC_LATENCY == 0) ? DONE : DRAIN;
      end else begin
        ch_sel_d = ch_sel_q + 1'b1;
      end
      DRAIN: if (drain_q == 3'(SRC_LATENCY - 1)) state_d = DONE;
             else drain_d = drain_q + 3'd1;
      DONE: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A tick while busy is dropped but recorded; the set beats a same-cycle clear.
    overrun_d = overrun_q;
    if (sample_tick && state_q != IDLE) overrun_d = 1'b1;
    else if (overrun_clr)               overrun_d = 1'b0;
  end

  // FSM and control registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      ch_sel_q  <= '0;
      drain_q   <= '0;
      shift_q   <= '0;
      mute_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_sel_q  <= ch_sel_d;
      drain_q   <= drain_d;
      shift_q   <= shift_d;
      mute_q    <= mute_d;
      overrun_q <= overrun_d;
      valid_q   <= load;
    end
  end

  assign in_scan = (state_q == SCAN);

  // Capture-valid tag follows ch_sel through the same latency as the engines.
  generate
    if (SRC_LATENCY == 0) begin : g_no_pipe
      assign cap_valid = in_scan;
    end else begin : g_pipe
      logic [SRC_LATENCY-1:0] pipe_q;
      // Shift the scan flag along so data arrives tagged in the right cycle.
      always_ff @(posedge clk) begin
        if (!nreset) pipe_q <= '0;
        else         pipe_q <= (pipe_q << 1) | SRC_LATENCY'(in_scan);
      end
      assign cap_valid = pipe_q[SRC_LATENCY-1];
    end
  endgenerate

  wts_mixer_mac #(
    .SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .ACC_W(ACC_W),
    .OUT_W(OUT_W), .SATURATE(SATURATE)
  ) u_mac_left (
    .clk(clk), .nreset(nreset), .clr_i(start), .cap_i(cap_valid),
    .en_i(ch_enable[0]), .sample_i(ch_sample), .volume_i(ch_volume),
    .load_i(load), .shift_i(shift_q), .mute_i(mute_q), .out_o(left_out)
  );

  wts_mixer_mac #(
    .SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .ACC_W(ACC_W),
    .OUT_W(OUT_W), .SATURATE(SATURATE)
  ) u_mac_right (
    .clk(clk), .nreset(nreset), .clr_i(start), .cap_i(cap_valid),
    .en_i(ch_enable[1]), .sample_i(ch_sample), .volume_i(ch_volume),
    .load_i(load), .shift_i(shift_q), .mute_i(mute_q), .out_o(right_out)
  );

  assign ch_sel    = ch_sel_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_wts_channel_mixer_tdm.sv
// Directed bench for wts_channel_mixer_tdm: a saturating and a wrapping
// instance share one channel-source model with two cycles of latency.
module tb_wts_channel_mixer_tdm;

  logic        clk = 1'b0;
  logic        nreset, sample_tick, mute, overrun_clr;
  logic [3:0]  master_shift;
  logic [3:0]  ch_sel0, ch_sel1;
  logic [7:0]  ch_sample;
  logic [3:0]  ch_volume;
  logic [1:0]  ch_enable;
  logic        busy0, busy1, valid0, valid1, ovr0, ovr1;
  logic [11:0] left0, right0, left1, right1;

  logic [7:0]  smp [12];
  logic [3:0]  vol [12];
  logic [1:0]  ena [12];
  logic [3:0]  sel_p1 = '0;
  logic [3:0]  sel_p2 = '0;

  int n_pass  = 0;
  int n_total = 0;
  int cyc;
  int pulses;

  always #5 clk = ~clk;

  // Channel engines: data for a select appears two cycles later.
  always @(posedge clk) begin
    sel_p1 <= ch_sel0;
    sel_p2 <= sel_p1;
  end
  assign ch_sample = smp[sel_p2];
  assign ch_volume = vol[sel_p2];
  assign ch_enable = ena[sel_p2];

  wts_channel_mixer_tdm #(.SATURATE(1)) dut_sat (
    .clk(clk), .nreset(nreset), .sample_tick(sample_tick),
    .master_shift(master_shift), .mute(mute), .overrun_clr(overrun_clr),
    .ch_sel(ch_sel0), .ch_sample(ch_sample), .ch_volume(ch_volume),
    .ch_enable(ch_enable), .busy(busy0), .out_valid(valid0),
    .left_out(left0), .right_out(right0), .overrun(ovr0)
  );

  wts_channel_mixer_tdm #(.SATURATE(0)) dut_wrap (
    .clk(clk), .nreset(nreset), .sample_tick(sample_tick),
    .master_shift(master_shift), .mute(mute), .overrun_clr(overrun_clr),
    .ch_sel(ch_sel1), .ch_sample(ch_sample), .ch_volume(ch_volume),
    .ch_enable(ch_enable), .busy(busy1), .out_valid(valid1),
    .left_out(left1), .right_out(right1), .overrun(ovr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_all(input logic [7:0] s, input logic [3:0] v, input logic [1:0] e);
    for (int i = 0; i < 12; i++) begin
      smp[i] = s; vol[i] = v; ena[i] = e;
    end
  endtask

  task automatic set_ch(input int i, input logic [7:0] s, input logic [3:0] v, input logic [1:0] e);
    smp[i] = s; vol[i] = v; ena[i] = e;
  endtask

  // Raise the tick for one cycle; returns in cycle T+1.
  task automatic tick(input logic [3:0] sh, input logic mu);
    master_shift = sh; mute = mu; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0; master_shift = 4'd0; mute = 1'b0;
  endtask

  // Advance until out_valid; cyc counts cycles since the tick cycle T.
  task automatic wait_valid(input int start, output int c);
    c = start;
    while (!valid0 && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic check_frame(input string tag, input int c,
                             input logic [11:0] el, input logic [11:0] er);
    check({tag, "_latency"}, c, 16);
    check({tag, "_busy_at_valid"}, busy0, 1'b0);
    check({tag, "_left"}, left0, el);
    check({tag, "_right"}, right0, er);
  endtask

  initial begin
    nreset = 1'b0; sample_tick = 1'b0; master_shift = 4'd0;
    mute = 1'b0; overrun_clr = 1'b0;
    set_all(8'd0, 4'd0, 2'b00);

    // 1. Reset state
    repeat (3) @(negedge clk);
    check("rst_left", left0, 12'h800);
    check("rst_right", right0, 12'h800);
    check("rst_busy", busy0, 1'b0);
    check("rst_valid", valid0, 1'b0);
    check("rst_overrun", ovr0, 1'b0);
    check("rst_sel", ch_sel0, 4'd0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // 2. Single channel; others carry data but zero volume
    set_all(8'd50, 4'd0, 2'b11);
    set_ch(3, 8'd100, 4'd15, 2'b01);
    tick(4'd0, 1'b0);
    check("s2_busy_t1", busy0, 1'b1);
    check("s2_sel_t1", ch_sel0, 4'd0);
    @(negedge clk);
    check("s2_sel_t2", ch_sel0, 4'd1);
    wait_valid(2, cyc);
    check_frame("s2", cyc, 12'hDDC, 12'h800);
    @(negedge clk);
    check("s2_valid_pulse", valid0, 1'b0);
    check("s2_hold", left0, 12'hDDC);

    // 3. Full scale: clip and wrap
    set_all(8'd127, 4'd15, 2'b11);
    tick(4'd0, 1'b0);
    wait_valid(1, cyc);
    check_frame("s3_pos", cyc, 12'hFFF, 12'hFFF);
    check("s4_wrap_left", left1, 12'h14C);
    check("s4_wrap_right", right1, 12'h14C);

    set_all(8'h80, 4'd15, 2'b11);
    tick(4'd0, 1'b0);
    wait_valid(1, cyc);
    check_frame("s3_neg", cyc, 12'h000, 12'h000);
    check("s4_wrap_neg", left1, 12'hE00);

    set_all(8'd127, 4'd15, 2'b11);
    tick(4'd4, 1'b0);
    wait_valid(1, cyc);
    check_frame("s3_shift4", cyc, 12'hD94, 12'hD94);
    check("s4_wrap_shift4", left1, 12'hD94);

    set_all(8'h80, 4'd15, 2'b11);
    tick(4'd4, 1'b0);
    wait_valid(1, cyc);
    check_frame("neg_shift4", cyc, 12'h260, 12'h260);

    // Mixed routing: left = -60+100 = 40, right = 100+7 = 107
    set_all(8'd0, 4'd0, 2'b00);
    set_ch(0, 8'hEC, 4'd3, 2'b01);
    set_ch(5, 8'd10, 4'd10, 2'b11);
    set_ch(11, 8'd7, 4'd1, 2'b10);
    tick(4'd0, 1'b0);
    wait_valid(1, cyc);
    check_frame("mixed", cyc, 12'h828, 12'h86B);

    tick(4'd0, 1'b1);
    wait_valid(1, cyc);
    check_frame("mute", cyc, 12'h800, 12'h800);

    // 5. Tick during a frame sets overrun, frame unaffected
    set_all(8'd50, 4'd0, 2'b11);
    set_ch(3, 8'd100, 4'd15, 2'b01);
    tick(4'd0, 1'b0);
    repeat (4) @(negedge clk);
    sample_tick = 1'b1; master_shift = 4'd4; mute = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0; master_shift = 4'd0; mute = 1'b0;
    check("ovr_set", ovr0, 1'b1);
    wait_valid(6, cyc);
    check_frame("ovr_frame", cyc, 12'hDDC, 12'h800);
    check("ovr_sticky", ovr0, 1'b1);

    // Back-to-back tick in the out_valid cycle; set beats clear in one cycle
    tick(4'd0, 1'b0);
    check("b2b_busy", busy0, 1'b1);
    check("b2b_valid_low", valid0, 1'b0);
    sample_tick = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("ovr_set_wins", ovr0, 1'b1);
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", ovr0, 1'b0);
    wait_valid(3, cyc);
    check_frame("b2b", cyc, 12'hDDC, 12'h800);

    // 6. Reset mid-frame aborts, then a clean frame follows
    set_all(8'd127, 4'd15, 2'b11);
    tick(4'd0, 1'b0);
    repeat (5) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    check("abort_left", left0, 12'h800);
    check("abort_right", right0, 12'h800);
    check("abort_busy", busy0, 1'b0);
    check("abort_sel", ch_sel0, 4'd0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid0) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    set_all(8'd50, 4'd0, 2'b11);
    set_ch(3, 8'd100, 4'd15, 2'b01);
    tick(4'd0, 1'b0);
    wait_valid(1, cyc);
    check_frame("after_abort", cyc, 12'hDDC, 12'h800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
